btn_event_ctrl: RTL and testbench
=================================

Name: btn_event_ctrl

Overview:
- Front-end controller for the board pushbuttons and switches.
- Synchronises and debounces N asynchronous inputs, turns each debounced rising edge into a pending event, and presents events one at a time to the main FSM.
- Arbitration is round-robin over a valid/ack handshake.
- After each acknowledged event a hold-off window runs, so the main FSM gets one request per press and is never flooded.

Parameters:
- N_BTN, 4: number of async inputs (1..16).
- DB_CYCLES, 50000: cycles an input must be stable before the debounced level changes (>=2).
- HOLDOFF_CYCLES, 1000000: cycles after an ack during which no new event is offered (>=1).
- CNT_W, 20: width of the debounce and hold-off counters. Must hold max(DB_CYCLES, HOLDOFF_CYCLES).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- btn_async, input, N_BTN: raw asynchronous button/switch inputs.
- btn_level, output, N_BTN: debounced levels.
- evt_valid, output, 1: an event is being offered.
- evt_id, output, IDW: index of the offered input. IDW = max(1, clog2(N_BTN)).
- evt_ack, input, 1: consumer accepts the offered event.
- evt_pending, output, N_BTN: pending-event bitmap.
- overrun, output, 1: sticky flag. Set when an edge arrives on an input whose pending bit is already set.
- overrun_clr, input, 1: clears overrun.

Behaviour:
- Reset (async assert, sync release): all sync flops, counters, btn_level, evt_pending, evt_valid, evt_id, overrun and rr_ptr go to 0. State = IDLE.
- Per channel, synchroniser: 2-flop synchroniser, giving s[i].
- Per channel, debounce:
  - If s[i] == btn_level[i], the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DB_CYCLES-1, btn_level[i] toggles on the next edge and the counter clears.
  - Latency from a clean input step to btn_level: 2 + DB_CYCLES cycles.
  - An input held high through reset release produces a rising level, and therefore an event, after that latency.
- Edge detect: rise[i] = btn_level[i] & ~btn_level_d[i]. Falling edges generate no event.
- Pending bit update:
  - rise[i] sets evt_pending[i].
  - An ack of channel i clears it.
  - If rise[i] and the clear for channel i happen in the same cycle, set wins and the new edge is kept.
  - rise[i] with the bit already set and no same-cycle clear sets overrun.
  - If the overrun set and overrun_clr happen in the same cycle, set wins.
- FSM state IDLE:
  - If evt_pending != 0, select the first set bit at or after rr_ptr, wrapping modulo N_BTN.
  - Next cycle: evt_id = that index, evt_valid = 1, state OFFER.
  - Decision to valid latency: 1 cycle.
- FSM state OFFER:
  - evt_valid and evt_id are held stable until evt_ack.
  - On evt_valid & evt_ack: clear evt_pending[evt_id], set rr_ptr = (evt_id+1) mod N_BTN, drop evt_valid next cycle, load the hold-off counter, go to HOLDOFF.
  - Ack while evt_valid is 0 is ignored.
- FSM state HOLDOFF:
  - Counter counts HOLDOFF_CYCLES cycles with evt_valid = 0, then goes to IDLE.
  - Edges occurring during hold-off are still recorded as pending.
- Minimum spacing between consecutive evt_valid rises: HOLDOFF_CYCLES + 2 cycles.
- Reset mid-OFFER or mid-HOLDOFF aborts immediately; the event is lost.

Decomposition:
- Package btn_pkg:
  - FSM state encoding (IDLE, OFFER, HOLDOFF).
  - IDW helper function.
  - Default constants for DB_CYCLES and HOLDOFF_CYCLES.
- Sub-module btn_debounce: one channel, containing synchroniser, counter and level register, with clk/rst/async_in/level/rise ports.
- btn_event_ctrl instantiates N_BTN copies and contains the pending register, the round-robin selector and the FSM.

Test Plan (DB_CYCLES=4, HOLDOFF_CYCLES=8, N_BTN=4 unless noted):
- Glitch rejection: pulse btn_async[0] high for 3 cycles -> btn_level[0] stays 0, no evt_valid.
- Clean press: btn_async[2] steps high and holds -> btn_level[2] rises exactly 6 cycles later. evt_valid=1 with evt_id=2 one cycle after pending[2] sets. Ack -> pending clears, evt_valid=0 for 8 cycles.
- Round-robin: channels 1 and 3 pending together, rr_ptr=0 -> id 1 offered first, then id 3 after hold-off. Then 1 and 3 again with rr_ptr=2 -> id 3 first.
- Hold-off and stall:
  - Ack held low for 20 cycles -> evt_valid/evt_id stable throughout.
  - An edge on channel 0 during HOLDOFF -> offered exactly 1 cycle after HOLDOFF ends.
- Overrun: two debounced presses on channel 1 with no ack -> overrun=1, pending[1]=1. overrun_clr -> overrun=0. Same-cycle rise and ack on the offered channel -> pending stays 1.
- Async reset asserted during OFFER -> evt_valid, evt_pending and btn_level become 0 without a clock edge. After release, an input held high yields one event after 6 cycles.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the pushbutton/switch event front end.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int DEF_DB_CYCLES      = 50000;
    localparam int DEF_HOLDOFF_CYCLES = 1000000;

    // Event index width; a single input still needs a one-bit id.
    function automatic int idw_f(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One input channel: 2-flop synchroniser, stability counter, debounced level
// and a one-cycle rising-edge pulse.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             meta_r;
    logic             sync_r;
    logic             level_r;
    logic             rise_r;
    logic             level_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Any agreement with the current level restarts the stability window.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        if (sync_r == level_r) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r == DB_LAST) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            level_nxt_s = ~level_r;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Synchroniser, counter, level and edge registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            meta_r  <= async_in;
            sync_r  <= meta_r;
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            rise_r  <= level_nxt_s & ~level_r;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;

endmodule

// File: rtl/btn_event_ctrl.sv
// Debounced button front end: per-input pending events, round-robin offer
// over a valid/ack handshake and a hold-off window after every accepted event.
module btn_event_ctrl
    import btn_pkg::*;
#(
    parameter int  N_BTN          = 4,
    parameter int  DB_CYCLES      = DEF_DB_CYCLES,
    parameter int  HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int  CNT_W          = 20,
    localparam int IDW            = idw_f(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_async,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    output logic [IDW-1:0]   evt_id,
    input  logic             evt_ack,
    output logic [N_BTN-1:0] evt_pending,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [IDW:0]     N_WIDE    = (IDW + 1)'(N_BTN);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [N_BTN-1:0]   rise_s;
    logic [N_BTN-1:0]   evt_pending_r;
    logic [N_BTN-1:0]   pending_nxt_s;
    logic [N_BTN-1:0]   clr_mask_s;
    logic               overrun_r;
    logic               overrun_nxt_s;
    logic               ovr_set_s;
    logic               evt_valid_r;
    logic               evt_valid_nxt_s;
    logic [IDW-1:0]     evt_id_r;
    logic [IDW-1:0]     evt_id_nxt_s;
    logic [IDW-1:0]     rr_ptr_r;
    logic [IDW-1:0]     rr_ptr_nxt_s;
    logic [CNT_W-1:0]   hold_cnt_r;
    logic [CNT_W-1:0]   hold_cnt_nxt_s;
    logic               ack_fire_s;
    logic               sel_found_s;
    logic [IDW-1:0]     sel_idx_s;
    logic [IDW:0]       scan_s;
    logic [IDW:0]       id_inc_s;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .async_in (btn_async[i]),
            .level    (btn_level[i]),
            .rise     (rise_s[i])
        );
    end

    // First pending input at or after rr_ptr, wrapping modulo N_BTN.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {IDW{1'b0}};
        scan_s      = {(IDW + 1){1'b0}};
        for (int k = 0; k < N_BTN; k++) begin
            scan_s = {1'b0, rr_ptr_r} + (IDW + 1)'(k);
            if (scan_s >= N_WIDE) begin
                scan_s = scan_s - N_WIDE;
            end else begin
                scan_s = scan_s;
            end
            if (!sel_found_s && evt_pending_r[scan_s[IDW-1:0]]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = scan_s[IDW-1:0];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Pending bitmap and overrun: a new edge always beats a same-cycle clear.
    always_comb begin
        clr_mask_s    = ack_fire_s ? (N_BTN'(1'b1) << evt_id_r) : {N_BTN{1'b0}};
        pending_nxt_s = (evt_pending_r & ~clr_mask_s) | rise_s;
        ovr_set_s     = |(rise_s & evt_pending_r & ~clr_mask_s);
        if (ovr_set_s) begin
            overrun_nxt_s = 1'b1;
        end else if (overrun_clr) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s) state_nxt_s = ST_OFFER;
                else             state_nxt_s = ST_IDLE;
            end
            ST_OFFER: begin
                if (evt_valid_r && evt_ack) state_nxt_s = ST_HOLDOFF;
                else                        state_nxt_s = ST_OFFER;
            end
            ST_HOLDOFF: begin
                if (hold_cnt_r == {CNT_W{1'b0}}) state_nxt_s = ST_IDLE;
                else                             state_nxt_s = ST_HOLDOFF;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of the offer registers, pointer and hold-off counter.
    always_comb begin
        evt_valid_nxt_s = evt_valid_r;
        evt_id_nxt_s    = evt_id_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        hold_cnt_nxt_s  = hold_cnt_r;
        ack_fire_s      = 1'b0;
        id_inc_s        = {1'b0, evt_id_r} + (IDW + 1)'(1);
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s) begin
                    evt_valid_nxt_s = 1'b1;
                    evt_id_nxt_s    = sel_idx_s;
                end else begin
                    evt_valid_nxt_s = 1'b0;
                end
            end
            ST_OFFER: begin
                if (evt_valid_r && evt_ack) begin
                    ack_fire_s      = 1'b1;
                    evt_valid_nxt_s = 1'b0;
                    hold_cnt_nxt_s  = HOLD_LAST;
                    rr_ptr_nxt_s    = (id_inc_s >= N_WIDE) ? {IDW{1'b0}} : id_inc_s[IDW-1:0];
                end else begin
                    evt_valid_nxt_s = evt_valid_r;
                end
            end
            ST_HOLDOFF: begin
                evt_valid_nxt_s = 1'b0;
                if (hold_cnt_r != {CNT_W{1'b0}}) begin
                    hold_cnt_nxt_s = hold_cnt_r - CNT_W'(1);
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r;
                end
            end
            default: evt_valid_nxt_s = 1'b0;
        endcase
    end

    // Datapath registers: offer, pointer, hold-off, pending and overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid_r   <= 1'b0;
            evt_id_r      <= {IDW{1'b0}};
            rr_ptr_r      <= {IDW{1'b0}};
            hold_cnt_r    <= {CNT_W{1'b0}};
            evt_pending_r <= {N_BTN{1'b0}};
            overrun_r     <= 1'b0;
        end else begin
            evt_valid_r   <= evt_valid_nxt_s;
            evt_id_r      <= evt_id_nxt_s;
            rr_ptr_r      <= rr_ptr_nxt_s;
            hold_cnt_r    <= hold_cnt_nxt_s;
            evt_pending_r <= pending_nxt_s;
            overrun_r     <= overrun_nxt_s;
        end
    end

    assign evt_valid   = evt_valid_r;
    assign evt_id      = evt_id_r;
    assign evt_pending = evt_pending_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl with short debounce and hold-off windows.
module tb_btn_event_ctrl;

    localparam int N_BTN = 4;
    localparam int DB    = 4;
    localparam int HOLD  = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn_async;
    logic [N_BTN-1:0] btn_level;
    logic             evt_valid;
    logic [1:0]       evt_id;
    logic             evt_ack;
    logic [N_BTN-1:0] evt_pending;
    logic             overrun;
    logic             overrun_clr;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    btn_event_ctrl #(
        .N_BTN          (N_BTN),
        .DB_CYCLES      (DB),
        .HOLDOFF_CYCLES (HOLD),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_async   (btn_async),
        .btn_level   (btn_level),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .evt_ack     (evt_ack),
        .evt_pending (evt_pending),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (evt_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(evt_valid), 32'd1);
    endtask

    task automatic do_ack();
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
    endtask

    // Monitor: every new offer must match the oldest expected event id.
    initial begin
        logic prev;
        int   exp_id;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (evt_valid && !prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_offer actual_id=%0d expected=none time=%0t", evt_id, $time);
                    end else begin
                        exp_id = exp_q.pop_front();
                        check("offer_id", 32'(evt_id), 32'(exp_id));
                    end
                end
                prev = evt_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; btn_async = 4'b0000; evt_ack = 1'b0; overrun_clr = 1'b0;
        tick(3);
        check("rst_level",   32'(btn_level),   32'd0);
        check("rst_valid",   32'(evt_valid),   32'd0);
        check("rst_pending", 32'(evt_pending), 32'd0);
        check("rst_overrun", 32'(overrun),     32'd0);
        check("rst_id",      32'(evt_id),      32'd0);
        rst = 1'b0;
        tick(2);

        // Glitch: three sampled cycles high must not change the level.
        btn_async[0] = 1'b1; tick(3); btn_async[0] = 1'b0; tick(12);
        check("glitch_level",   32'(btn_level[0]), 32'd0);
        check("glitch_pending", 32'(evt_pending),  32'd0);
        check("glitch_valid",   32'(evt_valid),    32'd0);

        // Clean press on channel 2: level after 6 cycles, offer one cycle after pending.
        exp_q.push_back(2);
        btn_async[2] = 1'b1;
        tick(5); check("press_level_5", 32'(btn_level[2]), 32'd0);
        tick(1); check("press_level_6", 32'(btn_level[2]), 32'd1);
        tick(1); check("press_pending", 32'(evt_pending), 32'b0100);
                 check("press_valid_pre", 32'(evt_valid), 32'd0);
        tick(1); check("press_valid", 32'(evt_valid), 32'd1);
                 check("press_id",    32'(evt_id),    32'd2);
        do_ack();
        for (int i = 0; i < HOLD; i++) begin
            check("holdoff_valid",   32'(evt_valid),   32'd0);
            check("holdoff_pending", 32'(evt_pending), 32'd0);
            tick(1);
        end
        btn_async[2] = 1'b0; tick(10);
        check("release_level", 32'(btn_level), 32'd0);

        // Round robin from rr_ptr = 0, then from rr_ptr = 2.
        rst = 1'b1; tick(2); rst = 1'b0; tick(1);
        exp_q.push_back(1); exp_q.push_back(3);
        btn_async = 4'b1010;
        wait_valid("rr0_first", 20);  check("rr0_first_id", 32'(evt_id), 32'd1);
        do_ack();
        wait_valid("rr0_second", 30); check("rr0_second_id", 32'(evt_id), 32'd3);
        do_ack();
        btn_async = 4'b0000; tick(10);
        exp_q.push_back(1);
        btn_async[1] = 1'b1;
        wait_valid("rr_set2", 20);    check("rr_set2_id", 32'(evt_id), 32'd1);
        do_ack();
        btn_async[1] = 1'b0; tick(10);
        exp_q.push_back(3); exp_q.push_back(1);
        btn_async = 4'b1010;
        wait_valid("rr2_first", 30);  check("rr2_first_id", 32'(evt_id), 32'd3);
        do_ack();
        wait_valid("rr2_second", 30); check("rr2_second_id", 32'(evt_id), 32'd1);
        do_ack();
        btn_async = 4'b0000; tick(12);

        // Stall for 20 cycles, then a new edge on channel 0 during hold-off.
        exp_q.push_back(0); exp_q.push_back(0);
        btn_async[0] = 1'b1;
        wait_valid("stall_offer", 20);
        for (int i = 0; i < 20; i++) begin
            check("stall_valid", 32'(evt_valid), 32'd1);
            check("stall_id",    32'(evt_id),    32'd0);
            if (i == 2) btn_async[0] = 1'b0;
            tick(1);
        end
        evt_ack = 1'b1; btn_async[0] = 1'b1;
        tick(1); evt_ack = 1'b0;
        tick(7); check("hold_edge_valid_a", 32'(evt_valid), 32'd0);
        tick(1); check("hold_edge_valid_b", 32'(evt_valid), 32'd0);
                 check("hold_edge_pending", 32'(evt_pending[0]), 32'd1);
        tick(1); check("hold_edge_offer",   32'(evt_valid), 32'd1);
                 check("hold_edge_id",      32'(evt_id),    32'd0);
        do_ack();
        btn_async[0] = 1'b0; tick(12);

        // Overrun on channel 1, clear, then a rise in the same cycle as its ack.
        exp_q.push_back(1);
        btn_async[1] = 1'b1;
        wait_valid("ovr_offer", 20); check("ovr_offer_id", 32'(evt_id), 32'd1);
        tick(1); btn_async[1] = 1'b0; tick(10); btn_async[1] = 1'b1; tick(8);
        check("ovr_set",     32'(overrun),        32'd1);
        check("ovr_pending", 32'(evt_pending[1]), 32'd1);
        check("ovr_valid",   32'(evt_valid),      32'd1);
        overrun_clr = 1'b1; tick(1); overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        btn_async[1] = 1'b0; tick(10);
        exp_q.push_back(1);
        btn_async[1] = 1'b1;
        tick(6); check("race_valid_pre", 32'(evt_valid), 32'd1);
        evt_ack = 1'b1; tick(1); evt_ack = 1'b0;
        check("race_pending", 32'(evt_pending[1]), 32'd1);
        check("race_overrun", 32'(overrun),        32'd0);
        check("race_valid",   32'(evt_valid),      32'd0);
        wait_valid("race_reoffer", 20); check("race_reoffer_id", 32'(evt_id), 32'd1);

        // Asynchronous reset in the middle of an offer.
        #2 rst = 1'b1;
        #1;
        check("arst_valid",   32'(evt_valid),   32'd0);
        check("arst_pending", 32'(evt_pending), 32'd0);
        check("arst_level",   32'(btn_level),   32'd0);
        tick(2);
        rst = 1'b0;
        exp_q.push_back(1);
        tick(5); check("arst_level_5", 32'(btn_level[1]), 32'd0);
        tick(1); check("arst_level_6", 32'(btn_level[1]), 32'd1);
        wait_valid("arst_offer", 20); check("arst_offer_id", 32'(evt_id), 32'd1);
        do_ack();
        btn_async = 4'b0000; tick(12);
        check("final_queue",   32'(exp_q.size()), 32'd0);
        check("final_pending", 32'(evt_pending),  32'd0);
        check("final_valid",   32'(evt_valid),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
